// File: rtl/memwb_arbiter.sv
// memwb_arbiter: two-master round-robin arbiter for the pipelined Wishbone B4 NOR memory bus.
// Outstanding transfers are drained before the bus changes hands so acks never reach the wrong master.
module memwb_arbiter #(
  parameter int ADDRBITS = 26,
  parameter int DATABITS = 16,
  parameter int MAXOUT   = 4,
  parameter int DRAINTMO = 255
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [1:0]            m_cyc_i,
  input  logic [1:0]            m_stb_i,
  input  logic [1:0]            m_we_i,
  input  logic [2*ADDRBITS-1:0] m_adr_i,
  input  logic [2*DATABITS-1:0] m_dat_i,
  output logic [DATABITS-1:0]   m_dat_o,
  output logic [1:0]            m_ack_o,
  output logic [1:0]            m_err_o,
  output logic [1:0]            m_stall_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDRBITS-1:0]   s_adr_o,
  output logic [DATABITS-1:0]   s_dat_o,
  input  logic [DATABITS-1:0]   s_dat_i,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_stall_i,
  output logic [1:0]            grant_o,
  output logic                  tmo_o
);
  localparam int CW = $clog2(MAXOUT + 1);
  localparam logic [15:0] TMO_LAST = 16'(DRAINTMO - 1);
  typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic own, lim, acc, rsp, fwd;
  logic [1:0] sel;
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q + CW'(acc) - CW'(rsp);
    tmo_d   = '0;
    case (state_q)
      IDLE: if (|m_cyc_i) begin
        state_d = OWN;
        owner_d = &m_cyc_i ? ~last_q : m_cyc_i[1];
      end
      OWN: if (!m_cyc_i[owner_q]) begin
        state_d = cnt_d == '0 ? IDLE : DRAIN;
        last_d  = owner_q;
      end
      DRAIN: begin
        tmo_d = tmo_q + 16'd1;
        if (cnt_d == '0 || tmo_o) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // Responses are only counted against real outstanding transfers; stray ones are dropped.
  always_comb begin
    own       = state_q == OWN;
    lim       = cnt_q == CW'(MAXOUT);
    sel       = owner_q ? 2'b10 : 2'b01;
    s_cyc_o   = state_q != IDLE;
    s_stb_o   = own & m_stb_i[owner_q] & ~lim;
    s_we_o    = m_we_i[owner_q];
    s_adr_o   = owner_q ? m_adr_i[2*ADDRBITS-1:ADDRBITS] : m_adr_i[ADDRBITS-1:0];
    s_dat_o   = owner_q ? m_dat_i[2*DATABITS-1:DATABITS] : m_dat_i[DATABITS-1:0];
    acc       = s_stb_o & ~s_stall_i;
    rsp       = (s_ack_i | s_err_i) & (cnt_q != '0);
    fwd       = own & m_cyc_i[owner_q] & (cnt_q != '0);
    m_ack_o   = fwd & s_ack_i ? sel : 2'b00;
    m_err_o   = fwd & s_err_i ? sel : 2'b00;
    m_stall_o = own ? ~sel | {2{s_stall_i | lim}} : 2'b11;
    m_dat_o   = s_dat_i;
    grant_o   = state_q == IDLE ? 2'b00 : sel;
    tmo_o     = state_q == DRAIN && tmo_q == TMO_LAST && !(rsp && cnt_q == CW'(1));
  end
endmodule

// File: tb/tb_memwb_arbiter.sv
// tb_memwb_arbiter: scenario tasks plus a slave model and an ack scoreboard for memwb_arbiter.
module tb_memwb_arbiter;
  localparam int AW = 26, DW = 16, MO = 4, TMO = 8;
  localparam logic [DW-1:0] KEY = 16'hBEEF ^ 16'h0123;
  logic clk_i = 0, reset_ni = 1;
  logic [1:0] m_cyc_i = '0, m_stb_i = '0, m_we_i = '0;
  logic [2*AW-1:0] m_adr_i = '0;
  logic [2*DW-1:0] m_dat_i = '0;
  logic [DW-1:0] m_dat_o, s_dat_o, s_dat_i = '0;
  logic [1:0] m_ack_o, m_err_o, m_stall_o, grant_o;
  logic s_cyc_o, s_stb_o, s_we_o, tmo_o;
  logic s_ack_i = 0, s_err_i = 0, s_stall_i = 0;
  logic [AW-1:0] s_adr_o;
  int vectors = 0, miscompares = 0;
  typedef struct packed {logic m; logic [DW-1:0] d;} exp_t;
  exp_t exq[$], keep[$];
  int acc_cnt[2] = '{0, 0}, ack_cnt[2] = '{0, 0};
  int ack_dly = 1, slv_acks = 0, cyc_n = 0;
  bit sl_drop = 0, stall_rand = 0;
  int due_q[$];
  logic [DW-1:0] dat_q[$];

  memwb_arbiter #(.ADDRBITS(AW), .DATABITS(DW), .MAXOUT(MO), .DRAINTMO(TMO)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .m_stall_o(m_stall_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i),
    .grant_o(grant_o), .tmo_o(tmo_o));

  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    return a[DW-1:0] ^ KEY;
  endfunction

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  // Slave: in-order acks ack_dly cycles after acceptance; optional random stall or dropped acks.
  initial forever begin
    step;
    cyc_n++;
    s_ack_i = 0;
    s_stall_i = stall_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    if (due_q.size() != 0 && due_q[0] <= cyc_n) begin
      void'(due_q.pop_front());
      s_dat_i = dat_q.pop_front();
      s_ack_i = 1;
      slv_acks++;
    end
    @(negedge clk_i);
    if (!reset_ni) begin
      due_q.delete();
      dat_q.delete();
    end else if (s_cyc_o && s_stb_o && !s_stall_i && !sl_drop) begin
      due_q.push_back(cyc_n + ack_dly);
      dat_q.push_back(rd_val(s_adr_o));
    end
  end

  // Scoreboard: expectations pushed on master-side acceptance, popped on each forwarded ack.
  initial forever begin
    @(negedge clk_i);
    if (!reset_ni) exq.delete();
    else begin
      if (m_ack_o != 2'b00) begin
        logic [1:0] eack;
        logic [DW-1:0] edat;
        eack = exq.size() == 0 ? 2'b00 : (exq[0].m ? 2'b10 : 2'b01);
        edat = exq.size() == 0 ? '0 : exq[0].d;
        vectors++;
        if (m_ack_o !== eack || m_dat_o !== edat) begin
          miscompares++;
          $display("FAIL sb_ack: ack=%b dat=%h, want ack=%b dat=%h (queued %0d)", m_ack_o, m_dat_o, eack, edat, exq.size());
        end
        for (int n = 0; n < 2; n++) if (m_ack_o[n]) ack_cnt[n]++;
        if (exq.size() != 0) void'(exq.pop_front());
      end
      keep = {};
      foreach (exq[i]) if (m_cyc_i[exq[i].m]) keep.push_back(exq[i]);
      exq = keep;
      for (int n = 0; n < 2; n++)
        if (m_cyc_i[n] && m_stb_i[n] && !m_stall_o[n]) begin
          exq.push_back('{m: 1'(n), d: rd_val(n == 1 ? m_adr_i[2*AW-1:AW] : m_adr_i[AW-1:0])});
          acc_cnt[n]++;
        end
    end
  end

  task automatic wait_acks(input int n, input int target, output bit ok);
    ok = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk_i);
      ok = ack_cnt[n] >= target;
    end
  endtask

  task automatic test_reset;
    #2 reset_ni = 0;
    #1;
    vectors++;
    if ({grant_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_stall_o, tmo_o} !== 11'b00_0_0_00_00_11_0) begin
      miscompares++;
      $display("FAIL reset_state: got %b, want %b", {grant_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_stall_o, tmo_o}, 11'b00_0_0_00_00_11_0);
    end
    repeat (2) step;
    reset_ni = 1;
    step;
  endtask

  task automatic test_single;
    ack_dly = 1;
    m_cyc_i[0] = 1; m_stb_i[0] = 1; m_adr_i[AW-1:0] = 26'h0000123; m_adr_i[2*AW-1:AW] = 26'h3FFFFFF;
    m_dat_i = {16'h2222, 16'h1111};
    @(negedge clk_i);
    vectors++;
    if ({grant_o, m_stall_o[0]} !== 3'b00_1) begin
      miscompares++;
      $display("FAIL arb_latency: grant/stall0=%b, want %b", {grant_o, m_stall_o[0]}, 3'b00_1);
    end
    step;
    @(negedge clk_i);
    vectors++;
    if ({grant_o, s_stb_o, m_stall_o[0], s_adr_o, s_dat_o} !== {2'b01, 1'b1, 1'b0, 26'h0000123, 16'h1111}) begin
      miscompares++;
      $display("FAIL single_grant: grant=%b stb=%b stall0=%b adr=%h dat=%h, want 01 1 0 0000123 1111", grant_o, s_stb_o, m_stall_o[0], s_adr_o, s_dat_o);
    end
    step;
    m_stb_i[0] = 0;
    @(negedge clk_i);
    vectors++;
    if ({m_ack_o, m_dat_o} !== {2'b01, 16'hBEEF}) begin
      miscompares++;
      $display("FAIL single_ack: ack=%b dat=%h, want 01 beef", m_ack_o, m_dat_o);
    end
    step;
    m_cyc_i[0] = 0;
    step;
    @(negedge clk_i);
    vectors++;
    if ({grant_o, s_cyc_o} !== 3'b00_0) begin
      miscompares++;
      $display("FAIL single_release: grant=%b cyc=%b, want 00 0", grant_o, s_cyc_o);
    end
    step;
  endtask

  task automatic test_round_robin;
    reset_ni = 0;
    step;
    reset_ni = 1;
    step;
    m_we_i = 2'b10; m_adr_i[2*AW-1:AW] = 26'h0ABCDEF;
    m_cyc_i = 2'b11;
    step;
    @(negedge clk_i);
    vectors++;
    if (grant_o !== 2'b01) begin
      miscompares++;
      $display("FAIL rr_first: grant=%b, want 01", grant_o);
    end
    step;
    m_cyc_i[0] = 0;
    step;
    step;
    @(negedge clk_i);
    vectors++;
    if ({grant_o, s_adr_o, s_dat_o, s_we_o} !== {2'b10, 26'h0ABCDEF, 16'h2222, 1'b1}) begin
      miscompares++;
      $display("FAIL rr_second: grant=%b adr=%h dat=%h we=%b, want 10 0abcdef 2222 1", grant_o, s_adr_o, s_dat_o, s_we_o);
    end
    step;
    m_cyc_i[0] = 1;
    step;
    m_cyc_i[1] = 0;
    step;
    m_cyc_i[1] = 1;
    step;
    @(negedge clk_i);
    vectors++;
    if (grant_o !== 2'b01) begin
      miscompares++;
      $display("FAIL rr_third: grant=%b, want 01", grant_o);
    end
    step;
    m_cyc_i = 2'b00; m_we_i = 2'b00;
    repeat (2) step;
  endtask

  task automatic test_burst_limit;
    int sent, b0, a0, a1;
    bit acc, ok;
    ack_dly = 8; b0 = acc_cnt[0]; a0 = ack_cnt[0]; a1 = ack_cnt[1]; sent = 0;
    m_cyc_i[0] = 1; m_stb_i[0] = 1; m_adr_i[AW-1:0] = 26'h0000200;
    for (int c = 0; c < 100 && sent < 6; c++) begin
      @(negedge clk_i);
      if (c == 7) begin
        vectors++;
        if (acc_cnt[0] - b0 != 4 || m_stall_o[0] !== 1'b1 || ack_cnt[0] != a0) begin
          miscompares++;
          $display("FAIL burst_limit: accepted=%0d stall0=%b acks=%0d, want 4 1 0", acc_cnt[0] - b0, m_stall_o[0], ack_cnt[0] - a0);
        end
      end
      acc = !m_stall_o[0];
      step;
      if (acc) begin
        sent++;
        m_adr_i[AW-1:0] = m_adr_i[AW-1:0] + 26'd1;
        if (sent == 6) m_stb_i[0] = 0;
      end
    end
    wait_acks(0, a0 + 6, ok);
    vectors++;
    if (!ok || sent != 6 || ack_cnt[1] != a1 || exq.size() != 0) begin
      miscompares++;
      $display("FAIL burst_acks: sent=%0d acks0=%0d acks1=%0d left=%0d, want 6 6 0 0", sent, ack_cnt[0] - a0, ack_cnt[1] - a1, exq.size());
    end
    step;
    m_cyc_i[0] = 0;
    repeat (2) step;
  endtask

  task automatic test_back_to_back;
    int sent, a0;
    bit acc, ok;
    ack_dly = 2; stall_rand = 1; a0 = ack_cnt[0]; sent = 0;
    m_cyc_i[0] = 1; m_stb_i[0] = 1; m_adr_i[AW-1:0] = AW'($urandom);
    for (int c = 0; c < 200 && sent < 8; c++) begin
      @(negedge clk_i);
      acc = !m_stall_o[0];
      step;
      if (acc) begin
        sent++;
        m_adr_i[AW-1:0] = AW'($urandom);
        if (sent == 8) m_stb_i[0] = 0;
      end
    end
    stall_rand = 0;
    wait_acks(0, a0 + 8, ok);
    vectors++;
    if (!ok || sent != 8 || exq.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_stall: sent=%0d acks=%0d left=%0d, want 8 8 0", sent, ack_cnt[0] - a0, exq.size());
    end
    step;
    m_cyc_i[0] = 0;
    repeat (2) step;
  endtask

  task automatic test_abort;
    int sent, s0;
    bit acc, found;
    ack_dly = 6; s0 = slv_acks; sent = 0; found = 0;
    m_cyc_i[1] = 1; m_stb_i[1] = 1; m_adr_i[2*AW-1:AW] = 26'h0000300;
    for (int c = 0; c < 50 && sent < 2; c++) begin
      @(negedge clk_i);
      acc = !m_stall_o[1];
      step;
      if (acc) begin
        sent++;
        m_adr_i[2*AW-1:AW] = m_adr_i[2*AW-1:AW] + 26'd1;
        if (sent == 2) begin
          m_stb_i[1] = 0; m_cyc_i[1] = 0; m_cyc_i[0] = 1;
        end
      end
    end
    step;
    @(negedge clk_i);
    vectors++;
    if ({s_cyc_o, s_stb_o, m_stall_o, grant_o[0]} !== 5'b1_0_11_0) begin
      miscompares++;
      $display("FAIL abort_drain: cyc=%b stb=%b stall=%b grant=%b, want 1 0 11 x0", s_cyc_o, s_stb_o, m_stall_o, grant_o);
    end
    for (int c = 0; c < 100 && !found; c++) begin
      step;
      @(negedge clk_i);
      found = grant_o == 2'b01;
    end
    vectors++;
    if (!found || slv_acks - s0 != 2 || due_q.size() != 0) begin
      miscompares++;
      $display("FAIL abort_handover: granted=%b drained=%0d pending=%0d, want 1 2 0", found, slv_acks - s0, due_q.size());
    end
    step;
    m_cyc_i[0] = 0;
    repeat (2) step;
  endtask

  task automatic test_drain_timeout;
    int sent, tmo_n, tmo_idx, g_idx;
    bit acc;
    sl_drop = 1; sent = 0; tmo_n = 0; tmo_idx = -1; g_idx = -1;
    m_cyc_i[1] = 1; m_stb_i[1] = 1; m_adr_i[2*AW-1:AW] = 26'h0000777;
    for (int c = 0; c < 50 && sent < 1; c++) begin
      @(negedge clk_i);
      acc = !m_stall_o[1];
      step;
      if (acc) begin
        sent = 1; m_stb_i[1] = 0; m_cyc_i[1] = 0; m_cyc_i[0] = 1;
      end
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (tmo_o) begin
        tmo_n++;
        if (tmo_idx < 0) tmo_idx = i;
      end
      if (grant_o == 2'b01 && g_idx < 0) g_idx = i;
      step;
    end
    vectors++;
    if (tmo_n != 1 || tmo_idx != 8 || g_idx != 10) begin
      miscompares++;
      $display("FAIL drain_timeout: pulses=%0d at=%0d grant_at=%0d, want 1 8 10", tmo_n, tmo_idx, g_idx);
    end
    sl_drop = 0;
    m_cyc_i[0] = 0;
    repeat (2) step;
  endtask

  task automatic test_reset_mid;
    int a0;
    bit ok, found;
    ack_dly = 8; found = 0;
    m_cyc_i[0] = 1; m_stb_i[0] = 1; m_adr_i[AW-1:0] = 26'h0000400;
    repeat (4) step;
    @(negedge clk_i);
    vectors++;
    if ({s_cyc_o, s_stb_o} !== 2'b11) begin
      miscompares++;
      $display("FAIL pre_reset_active: cyc/stb=%b, want 11", {s_cyc_o, s_stb_o});
    end
    #2 reset_ni = 0;
    #1;
    vectors++;
    if ({s_cyc_o, s_stb_o, grant_o, m_stall_o} !== 6'b0_0_00_11) begin
      miscompares++;
      $display("FAIL async_reset: cyc=%b stb=%b grant=%b stall=%b, want 0 0 00 11", s_cyc_o, s_stb_o, grant_o, m_stall_o);
    end
    m_cyc_i = 2'b00; m_stb_i = 2'b00;
    repeat (2) step;
    reset_ni = 1;
    step;
    ack_dly = 1; a0 = ack_cnt[0];
    m_cyc_i = 2'b11; m_stb_i[0] = 1; m_adr_i[AW-1:0] = 26'h0000555;
    step;
    @(negedge clk_i);
    vectors++;
    if (grant_o !== 2'b01) begin
      miscompares++;
      $display("FAIL reset_rearb: grant=%b, want 01", grant_o);
    end
    step;
    m_stb_i[0] = 0;
    wait_acks(0, a0 + 1, ok);
    step;
    m_cyc_i[0] = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      step;
      @(negedge clk_i);
      found = grant_o == 2'b10;
    end
    vectors++;
    if (!ok || !found || exq.size() != 0) begin
      miscompares++;
      $display("FAIL reset_resume: ack=%b grant1=%b left=%0d, want 1 1 0", ok, found, exq.size());
    end
    step;
    m_cyc_i = 2'b00;
    repeat (2) step;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_burst_limit;
    test_back_to_back;
    test_abort;
    test_drain_timeout;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
